// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with address checks, write gating and WB-to-store forwarding
module ex_mem_reg #(
  parameter int unsigned DM_WORDS = 4096
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall_In,
  input  logic        Flush_In,
  input  logic [5:0]  Op_In,
  input  logic [31:0] Pc_In,
  input  logic [31:0] Alu_In,
  input  logic [31:0] Rt_Data_In,
  input  logic [4:0]  Rt_In,
  input  logic [4:0]  Wa_In,
  input  logic        RegWrite_In,
  input  logic        MemWrite_In,
  input  logic [1:0]  Tnew_In,
  input  logic        Wb_RegWrite_In,
  input  logic [4:0]  Wb_Wa_In,
  input  logic [31:0] Wb_Data_In,
  output logic [5:0]  Op_Out,
  output logic [31:0] Pc_Out,
  output logic [31:0] Addr_Out,
  output logic [31:0] D_Out,
  output logic        MemWrite_Out,
  output logic [4:0]  Wa_Out,
  output logic        RegWrite_Out,
  output logic [1:0]  Tnew_Out,
  output logic        AdEL_Out,
  output logic        AdES_Out
);
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  logic [5:0]  op_q, op_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, rt_data_q, rt_data_d;
  logic [4:0]  rt_q, rt_d, wa_q, wa_d;
  logic [1:0]  tnew_q, tnew_d;
  logic        mem_write_q, mem_write_d, reg_write_q, reg_write_d;
  logic        adel_q, adel_d, ades_q, ades_d;
  logic        is_ld, is_st, misal, oor, bad;
  always_comb begin
    is_ld = Op_In inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    is_st = Op_In inside {OP_SW, OP_SH, OP_SB};
    misal = (Op_In == OP_LW || Op_In == OP_SW) ? |Alu_In[1:0] :
            (Op_In inside {OP_LH, OP_LHU, OP_SH}) ? Alu_In[0] : 1'b0;
    oor = (is_ld | is_st) & ({2'b00, Alu_In[31:2]} >= DM_WORDS);
    bad = misal | oor;
    // Flush beats Stall so a frozen pipe can still squash this stage
    op_d        = Flush_In ? '0 : Stall_In ? op_q        : Op_In;
    pc_d        = Flush_In ? '0 : Stall_In ? pc_q        : Pc_In;
    addr_d      = Flush_In ? '0 : Stall_In ? addr_q      : Alu_In;
    rt_data_d   = Flush_In ? '0 : Stall_In ? rt_data_q   : Rt_Data_In;
    rt_d        = Flush_In ? '0 : Stall_In ? rt_q        : Rt_In;
    wa_d        = Flush_In ? '0 : Stall_In ? wa_q        : Wa_In;
    tnew_d      = Flush_In ? '0 : Stall_In ? tnew_q      : (Tnew_In == 2'd0 ? 2'd0 : Tnew_In - 2'd1);
    mem_write_d = Flush_In ? '0 : Stall_In ? mem_write_q : MemWrite_In & ~bad;
    reg_write_d = Flush_In ? '0 : Stall_In ? reg_write_q : RegWrite_In & (Wa_In != 5'd0) & ~(is_ld & bad);
    adel_d      = Flush_In ? '0 : Stall_In ? adel_q      : is_ld & bad;
    ades_d      = Flush_In ? '0 : Stall_In ? ades_q      : is_st & bad;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q        <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      rt_data_q   <= '0;
      rt_q        <= '0;
      wa_q        <= '0;
      tnew_q      <= '0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
    end else begin
      op_q        <= op_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      rt_data_q   <= rt_data_d;
      rt_q        <= rt_d;
      wa_q        <= wa_d;
      tnew_q      <= tnew_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      adel_q      <= adel_d;
      ades_q      <= ades_d;
    end
  end
  assign D_Out        = (Wb_RegWrite_In && Wb_Wa_In == rt_q && rt_q != 5'd0) ? Wb_Data_In : rt_data_q;
  assign Op_Out       = op_q;
  assign Pc_Out       = pc_q;
  assign Addr_Out     = addr_q;
  assign MemWrite_Out = mem_write_q;
  assign Wa_Out       = wa_q;
  assign RegWrite_Out = reg_write_q;
  assign Tnew_Out     = tnew_q;
  assign AdEL_Out     = adel_q;
  assign AdES_Out     = ades_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: random + directed checks of ex_mem_reg against a behavioural model
module tb_ex_mem_reg;
  logic        Clk = 0, Reset, Stall_In, Flush_In;
  logic [5:0]  Op_In;
  logic [31:0] Pc_In, Alu_In, Rt_Data_In, Wb_Data_In;
  logic [4:0]  Rt_In, Wa_In, Wb_Wa_In;
  logic        RegWrite_In, MemWrite_In, Wb_RegWrite_In;
  logic [1:0]  Tnew_In;
  logic [5:0]  Op_Out;
  logic [31:0] Pc_Out, Addr_Out, D_Out;
  logic        MemWrite_Out, RegWrite_Out, AdEL_Out, AdES_Out;
  logic [4:0]  Wa_Out;
  logic [1:0]  Tnew_Out;

  int tests = 0, fails = 0;

  ex_mem_reg dut (
    .Clk(Clk), .Reset(Reset), .Stall_In(Stall_In), .Flush_In(Flush_In),
    .Op_In(Op_In), .Pc_In(Pc_In), .Alu_In(Alu_In), .Rt_Data_In(Rt_Data_In),
    .Rt_In(Rt_In), .Wa_In(Wa_In), .RegWrite_In(RegWrite_In), .MemWrite_In(MemWrite_In),
    .Tnew_In(Tnew_In), .Wb_RegWrite_In(Wb_RegWrite_In), .Wb_Wa_In(Wb_Wa_In),
    .Wb_Data_In(Wb_Data_In), .Op_Out(Op_Out), .Pc_Out(Pc_Out), .Addr_Out(Addr_Out),
    .D_Out(D_Out), .MemWrite_Out(MemWrite_Out), .Wa_Out(Wa_Out),
    .RegWrite_Out(RegWrite_Out), .Tnew_Out(Tnew_Out), .AdEL_Out(AdEL_Out), .AdES_Out(AdES_Out)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: access size per opcode, alignment by modulo, range by word division
  function automatic int acc_size(input logic [5:0] op);
    case (op)
      6'h23, 6'h2B: return 4;
      6'h21, 6'h25, 6'h29: return 2;
      6'h20, 6'h24, 6'h28: return 1;
      default: return 0;
    endcase
  endfunction
  function automatic bit is_load(input logic [5:0] op);
    return op == 6'h23 || op == 6'h21 || op == 6'h25 || op == 6'h20 || op == 6'h24;
  endfunction

  bit          m_valid = 0;
  logic [5:0]  m_op;
  logic [31:0] m_pc, m_addr, m_rtd;
  logic [4:0]  m_rt, m_wa;
  logic [1:0]  m_tnew;
  bit          m_mw, m_rw, m_adel, m_ades;

  always @(posedge Clk) begin
    if (Reset || Flush_In) begin
      m_op = 0; m_pc = 0; m_addr = 0; m_rtd = 0; m_rt = 0; m_wa = 0; m_tnew = 0;
      m_mw = 0; m_rw = 0; m_adel = 0; m_ades = 0;
      if (Reset) m_valid = 1;
    end else if (!Stall_In) begin
      int sz;
      bit bad;
      sz = acc_size(Op_In);
      bad = sz != 0 && ((Alu_In % sz) != 0 || (Alu_In / 4) >= 4096);
      m_op = Op_In; m_pc = Pc_In; m_addr = Alu_In; m_rtd = Rt_Data_In; m_rt = Rt_In; m_wa = Wa_In;
      m_tnew = (Tnew_In == 0) ? 2'd0 : 2'(Tnew_In - 1);
      m_mw = MemWrite_In && !bad;
      m_adel = is_load(Op_In) && bad;
      m_ades = sz != 0 && !is_load(Op_In) && bad;
      m_rw = RegWrite_In && Wa_In != 0 && !m_adel;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (m_valid) begin
      logic [31:0] d_exp;
      d_exp = (Wb_RegWrite_In && Wb_Wa_In == m_rt && m_rt != 0) ? Wb_Data_In : m_rtd;
      chk("op", 32'(Op_Out), 32'(m_op));
      chk("pc", Pc_Out, m_pc);
      chk("addr", Addr_Out, m_addr);
      chk("d", D_Out, d_exp);
      chk("wa", 32'(Wa_Out), 32'(m_wa));
      chk("tnew", 32'(Tnew_Out), 32'(m_tnew));
      chk("mw", 32'(MemWrite_Out), 32'(m_mw));
      chk("rw", 32'(RegWrite_Out), 32'(m_rw));
      chk("adel", 32'(AdEL_Out), 32'(m_adel));
      chk("ades", 32'(AdES_Out), 32'(m_ades));
    end
  end

  task automatic set_in(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] rtd, input logic [4:0] rt, input logic [4:0] wa,
                        input logic rw, input logic mw, input logic [1:0] tn);
    Op_In = op; Pc_In = pc; Alu_In = alu; Rt_Data_In = rtd; Rt_In = rt; Wa_In = wa;
    RegWrite_In = rw; MemWrite_In = mw; Tnew_In = tn;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [5:0] ops [12] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28,
                           6'h00, 6'h09, 6'h0F, 6'h22};

  initial begin
    Reset = 1; Stall_In = 0; Flush_In = 0;
    Wb_RegWrite_In = 0; Wb_Wa_In = 0; Wb_Data_In = 0;
    set_in(6'h3F, 32'h1, 32'hFFFF_FFFF, 32'h5555_5555, 5'd9, 5'd9, 1, 1, 2'd3);
    tick();
    Reset = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_op", 32'(Op_Out), 0);
    chk("rst_addr", Addr_Out, 0);
    chk("rst_d", D_Out, 0);
    chk("rst_tnew", 32'(Tnew_Out), 0);
    chk("rst_flags", {28'd0, MemWrite_Out, RegWrite_Out, AdEL_Out, AdES_Out}, 0);

    set_in(6'h2B, 32'h10, 32'h10, 32'hDEAD_BEEF, 5'd3, 5'd0, 0, 1, 0);
    tick();
    chk("sw_addr", Addr_Out, 32'h10);
    chk("sw_d", D_Out, 32'hDEAD_BEEF);
    chk("sw_mw", 32'(MemWrite_Out), 1);
    chk("sw_ades", 32'(AdES_Out), 0);

    set_in(6'h29, 32'h11, 32'h13, 32'h1, 5'd3, 5'd0, 0, 1, 0);
    tick();
    chk("sh_mw", 32'(MemWrite_Out), 0);
    chk("sh_ades", 32'(AdES_Out), 1);
    set_in(6'h23, 32'h12, 32'h4000, 32'h0, 5'd4, 5'd4, 1, 0, 2);
    tick();
    chk("lw_adel", 32'(AdEL_Out), 1);
    chk("lw_rw", 32'(RegWrite_Out), 0);
    chk("lw_ades_clr", 32'(AdES_Out), 0);
    set_in(6'h23, 32'h13, 32'h3FFC, 32'h0, 5'd4, 5'd4, 1, 0, 2);
    tick();
    chk("lw_edge_adel", 32'(AdEL_Out), 0);
    chk("lw_edge_rw", 32'(RegWrite_Out), 1);

    set_in(6'h28, 32'h14, 32'h21, 32'h77, 5'd5, 5'd0, 0, 1, 0);
    Wb_RegWrite_In = 1; Wb_Wa_In = 5; Wb_Data_In = 32'h12;
    tick();
    chk("fwd_hit", D_Out, 32'h12);
    set_in(6'h28, 32'h15, 32'h22, 32'h88, 5'd0, 5'd0, 0, 1, 0);
    Wb_Wa_In = 0;
    tick();
    chk("fwd_r0", D_Out, 32'h88);
    Wb_RegWrite_In = 0;

    set_in(6'h09, 32'h55, 32'h1234, 32'h9, 5'd1, 5'd7, 1, 0, 2);
    tick();
    chk("tnew_load", 32'(Tnew_Out), 1);
    Stall_In = 1;
    set_in(6'h23, 32'h99, 32'h8, 32'hA, 5'd2, 5'd3, 1, 0, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_tnew", 32'(Tnew_Out), 1);
      chk("stall_pc", Pc_Out, 32'h55);
      chk("stall_addr", Addr_Out, 32'h1234);
      chk("stall_op", 32'(Op_Out), 32'h09);
      chk("stall_wa", 32'(Wa_Out), 7);
    end
    Flush_In = 1;
    tick();
    chk("sf_op", 32'(Op_Out), 0);
    chk("sf_mw", 32'(MemWrite_Out), 0);
    chk("sf_rw", 32'(RegWrite_Out), 0);
    Flush_In = 0; Stall_In = 0;
    set_in(6'h2B, 32'h60, 32'h5, 32'hCAFE, 5'd6, 5'd0, 0, 1, 1);
    tick();
    chk("ades_mis", 32'(AdES_Out), 1);
    Stall_In = 1; Reset = 1;
    tick();
    chk("rst_stall_ades", 32'(AdES_Out), 0);
    chk("rst_stall_d", D_Out, 0);
    Stall_In = 0; Reset = 0;

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] alu;
      case ($urandom_range(0, 3))
        0: alu = $urandom_range(0, 64);
        1: alu = 32'h3FF8 + $urandom_range(0, 15);
        2: alu = $urandom;
        default: alu = $urandom_range(0, 8191);
      endcase
      set_in(ops[$urandom_range(0, 11)], $urandom, alu, $urandom, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 2'($urandom));
      Stall_In = ($urandom_range(0, 4) == 0);
      Flush_In = ($urandom_range(0, 9) == 0);
      Reset = ($urandom_range(0, 39) == 0);
      Wb_RegWrite_In = 1'($urandom);
      Wb_Wa_In = 5'($urandom_range(0, 7));
      Wb_Data_In = $urandom;
      tick();
    end
    Reset = 0; Stall_In = 0; Flush_In = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
